// File: rtl/vga_board_renderer.sv
// rtl/vga_board_renderer.sv - VGA raster timing and battleship board renderer
// Two-tick pipeline from raster counters to DAC pins; board state latched once per frame.
module vga_board_renderer #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter int   CLK_DIV   = 2,
  parameter logic SYNC_POL  = 1'b0,
  parameter int   N_BOARDS  = 2,
  parameter int   ROWS      = 5,
  parameter int   COLS      = 5,
  parameter int   CELL_PX   = 40,
  parameter int   BOARD_X0  = 40,
  parameter int   BOARD_Y0  = 140,
  parameter int   BOARD_GAP = 80,
  localparam int  BW        = (N_BOARDS > 1) ? $clog2(N_BOARDS) : 1,
  localparam int  RW        = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int  CW        = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int  NBITS     = N_BOARDS * ROWS * COLS * 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] boards_flat,
  input  logic             cursor_en,
  input  logic [BW-1:0]    cursor_board,
  input  logic [RW-1:0]    cursor_row,
  input  logic [CW-1:0]    cursor_col,
  output logic [7:0]       r,
  output logic [7:0]       g,
  output logic [7:0]       b,
  output logic             horiz_sync,
  output logic             vert_sync,
  output logic             vga_blank,
  output logic             vga_sync,
  output logic             clkVGA,
  output logic             frame_start,
  output logic [9:0]       pix_x,
  output logic [9:0]       pix_y
);

  localparam int HMAX        = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VMAX        = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW          = $clog2(HMAX);
  localparam int VW          = $clog2(VMAX);
  localparam int DW          = $clog2(CLK_DIV);
  localparam int BOARD_W     = COLS * CELL_PX;
  localparam int BOARD_H     = ROWS * CELL_PX;
  localparam int BOARD_PITCH = BOARD_W + BOARD_GAP;

  typedef struct packed {
    logic [9:0]    x;
    logic [9:0]    y;
    logic          active;
    logic          hs;
    logic          vs;
    logic          in_board;
    logic [BW-1:0] board;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          grid;
    logic          cursor;
  } s1_t;

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        blank;
    logic [9:0]  x;
    logic [9:0]  y;
  } s2_t;

  logic [DW-1:0]    div_q, div_d;
  logic [HW-1:0]    hcnt_q, hcnt_d;
  logic [VW-1:0]    vcnt_q, vcnt_d;
  logic [NBITS-1:0] shadow_q, shadow_d;
  logic             frame_start_q, frame_start_d;
  s1_t              s1_q, s1_d;
  s2_t              s2_q, s2_d;
  logic             tick, latch;

  int   x, y, bx, sub_x, sub_y, cell_idx;
  logic in_x, in_y, last_x, near_edge;
  logic [2:0]  cell_state;
  logic [23:0] cell_rgb;

  always_comb begin
    tick   = (div_q == DW'(CLK_DIV - 1));
    latch  = tick && (hcnt_q == HW'(HMAX - 1)) && (vcnt_q == VW'(V_ACTIVE - 1));
    div_d  = tick ? '0 : div_q + DW'(1);
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (tick) begin
      if (hcnt_q == HW'(HMAX - 1)) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == VW'(VMAX - 1)) ? '0 : vcnt_q + VW'(1);
      end else begin
        hcnt_d = hcnt_q + HW'(1);
      end
    end
    shadow_d      = latch ? boards_flat : shadow_q;
    frame_start_d = latch;
  end

  // Stage 1: locate the pixel with comparator chains against constant cell boundaries.
  always_comb begin
    x         = int'(hcnt_q);
    y         = int'(vcnt_q);
    bx        = 0;
    sub_x     = 0;
    sub_y     = 0;
    in_x      = 1'b0;
    last_x    = 1'b0;
    s1_d      = '0;
    s1_d.x    = 10'(hcnt_q);
    s1_d.y    = 10'(vcnt_q);
    s1_d.active = (x < H_ACTIVE) && (y < V_ACTIVE);
    s1_d.hs   = (x >= H_ACTIVE + H_FP && x < H_ACTIVE + H_FP + H_SYNC) ? SYNC_POL : ~SYNC_POL;
    s1_d.vs   = (y >= V_ACTIVE + V_FP && y < V_ACTIVE + V_FP + V_SYNC) ? SYNC_POL : ~SYNC_POL;
    for (int bi = 0; bi < N_BOARDS; bi++) begin
      bx = BOARD_X0 + bi * BOARD_PITCH;
      if (x >= bx && x < bx + BOARD_W) begin
        in_x       = 1'b1;
        last_x     = (x == bx + BOARD_W - 1);
        s1_d.board = BW'(bi);
        for (int c = 0; c < COLS; c++) begin
          if (x >= bx + c * CELL_PX) begin
            s1_d.col = CW'(c);
            sub_x    = x - bx - c * CELL_PX;
          end
        end
      end
    end
    for (int ri = 0; ri < ROWS; ri++) begin
      if (y >= BOARD_Y0 + ri * CELL_PX) begin
        s1_d.row = RW'(ri);
        sub_y    = y - BOARD_Y0 - ri * CELL_PX;
      end
    end
    in_y          = (y >= BOARD_Y0) && (y < BOARD_Y0 + BOARD_H);
    s1_d.in_board = in_x && in_y;
    s1_d.grid     = (sub_x == 0) || (sub_y == 0) || last_x || (y == BOARD_Y0 + BOARD_H - 1);
    near_edge     = (sub_x < 2) || (sub_x >= CELL_PX - 2) || (sub_y < 2) || (sub_y >= CELL_PX - 2);
    s1_d.cursor   = cursor_en && s1_d.in_board && near_edge &&
                    (cursor_board == s1_d.board) && (cursor_row == s1_d.row) &&
                    (cursor_col == s1_d.col);
  end

  always_comb begin
    cell_idx   = (int'(s1_q.board) * ROWS + int'(s1_q.row)) * COLS + int'(s1_q.col);
    cell_state = shadow_q[cell_idx * 3 +: 3];
    case (cell_state)
      3'd0:    cell_rgb = 24'h0000A0;
      3'd1:    cell_rgb = 24'h808080;
      3'd2:    cell_rgb = 24'hFF0000;
      3'd3:    cell_rgb = 24'hFFFFFF;
      default: cell_rgb = 24'hFF00FF;
    endcase
    s2_d       = '0;
    s2_d.hs    = s1_q.hs;
    s2_d.vs    = s1_q.vs;
    s2_d.blank = s1_q.active;
    s2_d.x     = s1_q.x;
    s2_d.y     = s1_q.y;
    if (!s1_q.active)        s2_d.rgb = 24'h000000;
    else if (s1_q.cursor)    s2_d.rgb = 24'hFFFF00;
    else if (!s1_q.in_board) s2_d.rgb = 24'h202020;
    else if (s1_q.grid)      s2_d.rgb = 24'h000000;
    else                     s2_d.rgb = cell_rgb;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q         <= '0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      shadow_q      <= '0;
      frame_start_q <= 1'b0;
      s1_q          <= '0;
      s1_q.hs       <= ~SYNC_POL;
      s1_q.vs       <= ~SYNC_POL;
      s2_q          <= '0;
      s2_q.hs       <= ~SYNC_POL;
      s2_q.vs       <= ~SYNC_POL;
    end else begin
      div_q         <= div_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      shadow_q      <= shadow_d;
      frame_start_q <= frame_start_d;
      if (tick) begin
        s1_q <= s1_d;
        s2_q <= s2_d;
      end
    end
  end

  assign r           = s2_q.rgb[23:16];
  assign g           = s2_q.rgb[15:8];
  assign b           = s2_q.rgb[7:0];
  assign horiz_sync  = s2_q.hs;
  assign vert_sync   = s2_q.vs;
  assign vga_blank   = s2_q.blank;
  assign pix_x       = s2_q.x;
  assign pix_y       = s2_q.y;
  assign vga_sync    = 1'b0;
  assign clkVGA      = (div_q >= DW'(CLK_DIV / 2));
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_board_renderer.sv
// tb/tb_vga_board_renderer.sv - self-checking bench for vga_board_renderer
// Small raster so several frames fit; a per-clock model plus directed pixel probes.
module tb_vga_board_renderer;

  localparam int H_ACTIVE = 64, H_FP = 4, H_SYNC = 8, H_BP = 4;
  localparam int V_ACTIVE = 40, V_FP = 2, V_SYNC = 2, V_BP = 4;
  localparam int CLK_DIV  = 2;
  localparam logic POL    = 1'b0;
  localparam int NB = 2, ROWS = 3, COLS = 4, CELL = 5, X0 = 3, Y0 = 6, GAP = 6;
  localparam int HMAX  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VMAX  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int F     = HMAX * VMAX;
  localparam int NBITS = NB * ROWS * COLS * 3;
  localparam int BOUND = 2 * F * CLK_DIV + 100;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NBITS-1:0] boards_flat = '0;
  logic             cursor_en = 1'b0;
  logic [0:0]       cursor_board = '0;
  logic [1:0]       cursor_row = '0;
  logic [1:0]       cursor_col = '0;
  logic [7:0]       r, g, b;
  logic             horiz_sync, vert_sync, vga_blank, vga_sync, clkVGA, frame_start;
  logic [9:0]       pix_x, pix_y;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vga_board_renderer #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CLK_DIV(CLK_DIV), .SYNC_POL(POL), .N_BOARDS(NB), .ROWS(ROWS), .COLS(COLS),
    .CELL_PX(CELL), .BOARD_X0(X0), .BOARD_Y0(Y0), .BOARD_GAP(GAP)
  ) dut (
    .clk(clk), .rst(rst), .boards_flat(boards_flat), .cursor_en(cursor_en),
    .cursor_board(cursor_board), .cursor_row(cursor_row), .cursor_col(cursor_col),
    .r(r), .g(g), .b(b), .horiz_sync(horiz_sync), .vert_sync(vert_sync),
    .vga_blank(vga_blank), .vga_sync(vga_sync), .clkVGA(clkVGA),
    .frame_start(frame_start), .pix_x(pix_x), .pix_y(pix_y)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] model_rgb(input int x, input int y, input logic [NBITS-1:0] sh);
    int bx0, cx, sx, ry, sy;
    logic [2:0] st;
    if (x >= H_ACTIVE || y >= V_ACTIVE) return 24'h000000;
    for (int bi = 0; bi < NB; bi++) begin
      bx0 = X0 + bi * (COLS * CELL + GAP);
      if (x >= bx0 && x < bx0 + COLS * CELL && y >= Y0 && y < Y0 + ROWS * CELL) begin
        cx = (x - bx0) / CELL;
        sx = (x - bx0) % CELL;
        ry = (y - Y0) / CELL;
        sy = (y - Y0) % CELL;
        if (cursor_en && bi == int'(cursor_board) && ry == int'(cursor_row) &&
            cx == int'(cursor_col) &&
            (sx < 2 || sx > CELL - 3 || sy < 2 || sy > CELL - 3))
          return 24'hFFFF00;
        if (sx == 0 || sy == 0 || x == bx0 + COLS * CELL - 1 || y == Y0 + ROWS * CELL - 1)
          return 24'h000000;
        st = sh[((bi * ROWS + ry) * COLS + cx) * 3 +: 3];
        case (st)
          3'd0:    return 24'h0000A0;
          3'd1:    return 24'h808080;
          3'd2:    return 24'hFF0000;
          3'd3:    return 24'hFFFFFF;
          default: return 24'hFF00FF;
        endcase
      end
    end
    return 24'h202020;
  endfunction

  int               edges = 0;
  logic [NBITS-1:0] bf_at_edge = '0;
  logic [NBITS-1:0] model_shadow = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else begin
      edges      <= edges + 1;
      bf_at_edge <= boards_flat;
    end
  end

  // Output n ticks after release shows raster position n-2; the latch tick reloads the model shadow.
  always @(negedge clk) begin : compare
    int t, q, x, y;
    logic exp_fs, exp_ck, exp_hs, exp_vs, exp_bl;
    if (rst) begin
      model_shadow = '0;
      check("rst_rgb", 32'({r, g, b}), 32'h0);
      check("rst_sync", 32'({horiz_sync, vert_sync, vga_blank, vga_sync}), 32'({~POL, ~POL, 2'b00}));
      check("rst_pix", 32'({pix_x, pix_y}), 32'h0);
      check("rst_fs_clk", 32'({frame_start, clkVGA}), 32'h0);
    end else begin
      t      = edges / CLK_DIV;
      exp_fs = (edges > 0) && (edges % CLK_DIV == 0) && (t % F == V_ACTIVE * HMAX);
      if (exp_fs) model_shadow = bf_at_edge;
      exp_ck = (edges % CLK_DIV) >= CLK_DIV / 2;
      check("frame_start_clkvga", 32'({frame_start, clkVGA}), 32'({exp_fs, exp_ck}));
      if (t < 2) begin
        check("early_rgb", 32'({r, g, b}), 32'h0);
        check("early_sync", 32'({horiz_sync, vert_sync, vga_blank, vga_sync}), 32'({~POL, ~POL, 2'b00}));
        check("early_pix", 32'({pix_x, pix_y}), 32'h0);
      end else begin
        q      = (t - 2) % F;
        x      = q % HMAX;
        y      = q / HMAX;
        exp_hs = (x >= H_ACTIVE + H_FP && x < H_ACTIVE + H_FP + H_SYNC) ? POL : ~POL;
        exp_vs = (y >= V_ACTIVE + V_FP && y < V_ACTIVE + V_FP + V_SYNC) ? POL : ~POL;
        exp_bl = (x < H_ACTIVE) && (y < V_ACTIVE);
        check("model_rgb", 32'({r, g, b}), 32'(model_rgb(x, y, model_shadow)));
        check("model_sync", 32'({horiz_sync, vert_sync, vga_blank, vga_sync}),
              32'({exp_hs, exp_vs, exp_bl, 1'b0}));
        check("model_pix", 32'({pix_x, pix_y}), 32'({10'(x), 10'(y)}));
      end
    end
  end

  task automatic set_cell(input int bi, input int ri, input int ci, input logic [2:0] v);
    boards_flat[((bi * ROWS + ri) * COLS + ci) * 3 +: 3] = v;
  endtask

  task automatic probe(input int x, input int y, input logic [23:0] exp, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!(int'(pix_x) == x && int'(pix_y) == y) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) begin
      tests++;
      fails++;
      $display("FAIL %s: pixel (%0d,%0d) never reached, required within %0d clocks", nm, x, y, BOUND);
    end else begin
      check(nm, 32'({r, g, b}), 32'(exp));
    end
  endtask

  task automatic wait_fs(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (frame_start !== 1'b1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) begin
      tests++;
      fails++;
      $display("FAIL %s: frame_start got 0, required a pulse within %0d clocks", nm, BOUND);
    end
  endtask

  task automatic wait_row(input int y);
    int n;
    n = 0;
    while (int'(pix_y) != y && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) begin
      tests++;
      fails++;
      $display("FAIL wait_row: pix_y got %0d, required %0d", pix_y, y);
    end
  endtask

  initial begin : main
    logic [NBITS-1:0] pin_sh;
    int n;
    pin_sh = '0;
    pin_sh[2:0] = 3'd2;
    check("pin_model_hit", 32'(model_rgb(5, 8, pin_sh)), 32'h00FF0000);
    check("pin_model_grid", 32'(model_rgb(3, 8, pin_sh)), 32'h0);
    check("pin_model_outside", 32'(model_rgb(55, 19, pin_sh)), 32'h00202020);

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    set_cell(0, 0, 0, 3'd2);
    set_cell(1, 2, 3, 3'd6);
    set_cell(0, 1, 2, 3'd1);

    probe(5, 8, 24'h0000A0, "empty_before_latch");
    wait_fs("fs_first");
    probe(3, 8, 24'h000000, "grid_first_col");
    probe(5, 8, 24'hFF0000, "hit_red");
    probe(22, 8, 24'h000000, "grid_last_col");
    wait_row(10);
    set_cell(0, 0, 0, 3'd3);
    probe(46, 18, 24'hFF00FF, "reserved_magenta");
    probe(55, 19, 24'h202020, "outside_grey");
    probe(70, 19, 24'h000000, "hblank_black");
    probe(1, 30, 24'h202020, "outside_below");
    wait_fs("fs_second");
    probe(5, 8, 24'hFFFFFF, "miss_white_next_frame");

    wait_fs("fs_third");
    cursor_en    = 1'b1;
    cursor_board = 1'b1;
    cursor_row   = 2'd1;
    cursor_col   = 2'd2;
    probe(41, 11, 24'hFFFF00, "cursor_top_edge");
    probe(41, 13, 24'h0000A0, "cursor_interior");
    probe(42, 13, 24'hFFFF00, "cursor_right_band");

    wait_fs("fs_fourth");
    cursor_row = 2'd3;
    probe(41, 11, 24'h000000, "cursor_oor_grid");
    probe(42, 13, 24'h0000A0, "cursor_oor_cell");

    wait_row(15);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_rgb", 32'({r, g, b}), 32'h0);
    check("async_rst_misc", 32'({horiz_sync, vert_sync, vga_blank, frame_start, clkVGA, pix_x, pix_y}),
          32'({~POL, ~POL, 3'b000, 20'h0}));
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (horiz_sync !== POL && n < BOUND);
    check("hsync_after_reset_clks", 32'(n), 32'((H_ACTIVE + H_FP + 2) * CLK_DIV));
    probe(5, 8, 24'h0000A0, "shadow_cleared_by_reset");
    wait_fs("fs_after_reset");
    probe(5, 8, 24'hFFFFFF, "relatch_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

endmodule
